// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED keyframe sequencer.
// Holds the FSM state encoding, the slot record and the per-channel fade step helper.
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FADE = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [23:0] color;
    logic [15:0] hold_ms;
  } slot_t;

  localparam int NUM_SLOTS = 8;
  localparam int SLOT_W    = 3;

  // One LSB toward the target; saturates so a channel can never overshoot.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) begin
      return cur + 8'd1;
    end else if (cur > tgt) begin
      return cur - 8'd1;
    end else begin
      return cur;
    end
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Slot-write bus between the host/config source and the sequencer.
// A slot write is accepted on any cycle where wr_valid and wr_ready are both high.
interface led_sequencer_if;
  import led_seq_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [SLOT_W-1:0] wr_addr;
  logic [23:0]       wr_color;
  logic [15:0]       wr_hold_ms;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_color,
    output wr_hold_ms,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_color,
    input  wr_hold_ms,
    output wr_ready
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider producing a registered one-cycle ms_tick every CLK_FREQ/TICK_HZ cycles.
// Only rst clears it; no backpressure, the tick is a pure strobe.
module tick_prescaler #(
  parameter int CLK_FREQ = 12000000,
  parameter int TICK_HZ  = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic ms_tick
);

  localparam int TC    = CLK_FREQ / TICK_HZ - 1;
  localparam int CNT_W = (TC > 0) ? $clog2(TC + 1) : 1;
  localparam logic [CNT_W-1:0] TC_V = CNT_W'(TC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == TC_V) ? '0 : cnt_q + CNT_W'(1);
    tick_d = (cnt_q == TC_V);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign ms_tick = tick_q;

endmodule

// File: rtl/led_sequencer.sv
// Keyframe colour sequencer: cross-fades RGB duties slot to slot, then holds each slot's colour.
// All outputs registered, reacting one edge after start/stop/tick; wr_ready is low while fading.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int CLK_FREQ   = 12000000,
  parameter int TICK_HZ    = 1000,
  parameter int FADE_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst,
  led_sequencer_if.slave    wr_if,
  input  logic [SLOT_W-1:0] seq_last,
  input  logic              start,
  input  logic              stop,
  output logic [7:0]        red_duty,
  output logic [7:0]        green_duty,
  output logic [7:0]        blue_duty,
  output logic [SLOT_W-1:0] slot_idx,
  output logic              busy,
  output logic              wrap
);

  localparam int FDIV_W = (FADE_TICKS > 1) ? $clog2(FADE_TICKS) : 1;
  localparam logic [FDIV_W-1:0] FDIV_TC = FDIV_W'(FADE_TICKS - 1);

  logic ms_tick;

  tick_prescaler #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_HZ  (TICK_HZ)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .ms_tick (ms_tick)
  );

  state_t            state_q, state_d;
  slot_t             slot_q [NUM_SLOTS];
  slot_t             slot_d [NUM_SLOTS];
  logic [7:0]        red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic [SLOT_W-1:0] slot_idx_q, slot_idx_d;
  logic [15:0]       hold_q, hold_d;
  logic [FDIV_W-1:0] fdiv_q, fdiv_d;
  logic              busy_q, busy_d;
  logic              wrap_q, wrap_d;
  logic              wr_ready_q, wr_ready_d;

  slot_t             cur_slot;
  logic              at_target;
  logic              fade_step;
  logic [SLOT_W-1:0] next_idx;

  always_comb begin
    cur_slot  = slot_q[slot_idx_q];
    at_target = ({red_q, grn_q, blu_q} == cur_slot.color);
    fade_step = ms_tick && (fdiv_q == FDIV_TC);
    // >= so that lowering seq_last below the current slot still wraps cleanly.
    next_idx  = (slot_idx_q >= seq_last) ? '0 : slot_idx_q + SLOT_W'(1);
  end

  always_comb begin
    slot_d = slot_q;
    if (wr_if.wr_valid && wr_ready_q) begin
      slot_d[wr_if.wr_addr] = '{color: wr_if.wr_color, hold_ms: wr_if.wr_hold_ms};
    end
  end

  always_comb begin
    state_d    = state_q;
    red_d      = red_q;
    grn_d      = grn_q;
    blu_d      = blu_q;
    slot_idx_d = slot_idx_q;
    hold_d     = hold_q;
    fdiv_d     = fdiv_q;
    wrap_d     = 1'b0;

    if (ms_tick) begin
      fdiv_d = (fdiv_q == FDIV_TC) ? '0 : fdiv_q + FDIV_W'(1);
    end

    if (stop) begin
      state_d    = IDLE;
      red_d      = 8'd0;
      grn_d      = 8'd0;
      blu_d      = 8'd0;
      slot_idx_d = '0;
      hold_d     = '0;
    end else if (start) begin
      // Restart keeps the present duties so the new fade starts where the old one left off.
      state_d    = FADE;
      slot_idx_d = '0;
      fdiv_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
        end
        FADE: begin
          if (at_target) begin
            state_d = HOLD;
            hold_d  = cur_slot.hold_ms;
          end else if (fade_step) begin
            red_d = step_toward(red_q, cur_slot.color[23:16]);
            grn_d = step_toward(grn_q, cur_slot.color[15:8]);
            blu_d = step_toward(blu_q, cur_slot.color[7:0]);
          end
        end
        HOLD: begin
          if (hold_q == '0) begin
            state_d    = FADE;
            slot_idx_d = next_idx;
            wrap_d     = (next_idx == '0);
            fdiv_d     = '0;
          end else if (ms_tick) begin
            hold_d = hold_q - 16'd1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d     = (state_d != IDLE);
    wr_ready_d = (state_d != FADE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      red_q      <= 8'd0;
      grn_q      <= 8'd0;
      blu_q      <= 8'd0;
      slot_idx_q <= '0;
      hold_q     <= '0;
      fdiv_q     <= '0;
      busy_q     <= 1'b0;
      wrap_q     <= 1'b0;
      wr_ready_q <= 1'b1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      red_q      <= red_d;
      grn_q      <= grn_d;
      blu_q      <= blu_d;
      slot_idx_q <= slot_idx_d;
      hold_q     <= hold_d;
      fdiv_q     <= fdiv_d;
      busy_q     <= busy_d;
      wrap_q     <= wrap_d;
      wr_ready_q <= wr_ready_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign red_duty       = red_q;
  assign green_duty     = grn_q;
  assign blue_duty      = blu_q;
  assign slot_idx       = slot_idx_q;
  assign busy           = busy_q;
  assign wrap           = wrap_q;
  assign wr_if.wr_ready = wr_ready_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer at 10 cycles per tick and one tick per fade step.
`timescale 1ns/1ps
module tb_led_sequencer;
  import led_seq_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [SLOT_W-1:0] seq_last;
  logic              start;
  logic              stop;
  logic [7:0]        red_duty, green_duty, blue_duty;
  logic [SLOT_W-1:0] slot_idx;
  logic              busy;
  logic              wrap;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_sequencer_if wr_if ();

  led_sequencer #(
    .CLK_FREQ   (1000),
    .TICK_HZ    (100),
    .FADE_TICKS (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_if      (wr_if),
    .seq_last   (seq_last),
    .start      (start),
    .stop       (stop),
    .red_duty   (red_duty),
    .green_duty (green_duty),
    .blue_duty  (blue_duty),
    .slot_idx   (slot_idx),
    .busy       (busy),
    .wrap       (wrap)
  );

  typedef struct {
    logic [23:0] color;
    logic [7:0]  er;
    logic [7:0]  eg;
    logic [7:0]  eb;
    int          steps;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic int dif(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
  endfunction

  task automatic write_slot(input logic [2:0] addr, input logic [23:0] color, input logic [15:0] hold);
    chk("wr_ready_before_write", wr_if.wr_ready, 1'b1);
    wr_if.wr_valid   = 1'b1;
    wr_if.wr_addr    = addr;
    wr_if.wr_color   = color;
    wr_if.wr_hold_ms = hold;
    step();
    wr_if.wr_valid   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called one edge after entry to FADE; returns edges since the start edge and duty jumps seen.
  task automatic wait_hold(output int cyc, output int jumps);
    logic [7:0] pr, pg, pb;
    cyc   = 1;
    jumps = 0;
    while (!wr_if.wr_ready && cyc < 4000) begin
      pr = red_duty; pg = green_duty; pb = blue_duty;
      step();
      cyc++;
      if (dif(pr, red_duty) > 1 || dif(pg, green_duty) > 1 || dif(pb, blue_duty) > 1) jumps++;
    end
  endtask

  task automatic wait_wrap(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!wrap && cyc < 2000);
  endtask

  task automatic wait_idx(input logic [2:0] idx, output int cyc);
    cyc = 0;
    while (slot_idx !== idx && cyc < 3000) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    int cyc, jumps, c, bad;
    logic [23:0] prev;

    vecs[0] = '{color: 24'hFF0000, er: 8'hFF, eg: 8'h00, eb: 8'h00, steps: 255};
    vecs[1] = '{color: 24'hFF0000, er: 8'hFF, eg: 8'h00, eb: 8'h00, steps: 0};
    vecs[2] = '{color: 24'h8040C0, er: 8'h80, eg: 8'h40, eb: 8'hC0, steps: 192};
    vecs[3] = '{color: 24'h808080, er: 8'h80, eg: 8'h80, eb: 8'h80, steps: 64};
    vecs[4] = '{color: 24'h7F8181, er: 8'h7F, eg: 8'h81, eb: 8'h81, steps: 1};
    vecs[5] = '{color: 24'h000000, er: 8'h00, eg: 8'h00, eb: 8'h00, steps: 129};

    rst = 1'b1; start = 1'b0; stop = 1'b0; seq_last = 3'd0;
    wr_if.wr_valid = 1'b0; wr_if.wr_addr = 3'd0; wr_if.wr_color = 24'd0; wr_if.wr_hold_ms = 16'd0;
    step();
    step();
    rst = 1'b0;
    chk("rst_duties", {red_duty, green_duty, blue_duty}, 24'h000000);
    chk("rst_slot_idx", slot_idx, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_wr_ready", wr_if.wr_ready, 1'b1);

    // Chained single-slot fades; each restart begins from the previous hold colour.
    prev = 24'h000000;
    for (int i = 0; i < 6; i++) begin
      write_slot(3'd0, vecs[i].color, 16'd1000);
      seq_last = 3'd0;
      pulse_start();
      chk("busy_after_start", busy, 1'b1);
      chk("no_jump_on_start", {red_duty, green_duty, blue_duty}, prev);
      wait_hold(cyc, jumps);
      chk("fade_final", {red_duty, green_duty, blue_duty}, {vecs[i].er, vecs[i].eg, vecs[i].eb});
      if (vecs[i].steps == 0) chk_rng("fade_cycles", cyc, 2, 2);
      else chk_rng("fade_cycles", cyc, 10 * vecs[i].steps - 7, 10 * vecs[i].steps + 2);
      chk("fade_single_lsb", jumps, 0);
      chk("fade_slot_idx", slot_idx, 3'd0);
      prev = {vecs[i].er, vecs[i].eg, vecs[i].eb};
    end

    // Single slot with hold 3: wrap, then a 1-cycle fade to the same colour.
    write_slot(3'd0, 24'h050000, 16'd3);
    pulse_start();
    wait_hold(cyc, jumps);
    chk_rng("ramp5_cycles", cyc, 43, 52);
    chk("ramp5_red", red_duty, 8'h05);
    wait_wrap(c);
    chk_rng("hold3_cycles", c, 22, 31);
    chk("wrap_slot_idx", slot_idx, 3'd0);
    chk("wrap_in_fade", wr_if.wr_ready, 1'b0);
    step();
    chk("wrap_one_cycle", wrap, 1'b0);
    chk("same_color_fade_1cyc", wr_if.wr_ready, 1'b1);
    chk("busy_in_hold", busy, 1'b1);

    // Handshake: write held through FADE, accepted on the first HOLD cycle.
    write_slot(3'd0, 24'h030303, 16'd5);
    pulse_start();
    wr_if.wr_valid = 1'b1; wr_if.wr_addr = 3'd0;
    wr_if.wr_color = 24'h010101; wr_if.wr_hold_ms = 16'd1;
    chk("wr_blocked_in_fade", wr_if.wr_ready, 1'b0);
    wait_hold(cyc, jumps);
    chk_rng("hs_fade_cycles", cyc, 23, 32);
    chk("no_write_in_fade", {red_duty, green_duty, blue_duty}, 24'h030303);
    step();
    wr_if.wr_valid = 1'b0;
    wait_wrap(c);
    chk_rng("hold_not_reloaded", c + 1, 42, 51);
    wait_hold(cyc, jumps);
    chk_rng("new_slot_fade", cyc, 13, 22);
    chk("new_slot_color", {red_duty, green_duty, blue_duty}, 24'h010101);
    wait_wrap(c);
    chk_rng("new_slot_hold", c, 2, 11);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy", busy, 1'b0);

    // Two-slot crossfade with red and blue moving in lockstep.
    write_slot(3'd0, 24'h200000, 16'd0);
    write_slot(3'd1, 24'h000020, 16'd0);
    seq_last = 3'd1;
    pulse_start();
    wait_idx(3'd1, c);
    chk("xf_reach_slot1", c < 3000, 1'b1);
    chk("xf_slot0_color", {red_duty, green_duty, blue_duty}, 24'h200000);
    chk("xf_no_wrap_to_1", wrap, 1'b0);
    bad = 0;
    c = 0;
    while (slot_idx == 3'd1 && c < 3000) begin
      if (int'(red_duty) + int'(blue_duty) != 32 || green_duty != 8'd0) bad++;
      step();
      c++;
    end
    chk("xf_lockstep", bad, 0);
    chk("xf_back_to_0", slot_idx, 3'd0);
    chk("xf_wrap", wrap, 1'b1);
    chk("xf_slot1_color", {red_duty, green_duty, blue_duty}, 24'h000020);

    // Stop mid-FADE.
    wait_idx(3'd1, c);
    chk("xf_reach_slot1_again", c < 3000, 1'b1);
    repeat (50) step();
    chk("midfade_busy", busy, 1'b1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_duties", {red_duty, green_duty, blue_duty}, 24'h000000);
    chk("stop_busy_mid", busy, 1'b0);
    chk("stop_wr_ready", wr_if.wr_ready, 1'b1);

    // start and stop together: stop wins.
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", busy, 1'b0);
    repeat (5) step();
    chk("start_stop_idle", busy, 1'b0);

    // Lowering seq_last below the current slot wraps on the next advance.
    for (int i = 0; i < 8; i++) write_slot(3'(i), 24'h000000, 16'd0);
    seq_last = 3'd7;
    pulse_start();
    wait_idx(3'd5, c);
    chk("reach_slot5", c < 3000, 1'b1);
    seq_last = 3'd2;
    c = 0;
    while (slot_idx == 3'd5 && c < 100) begin
      step();
      c++;
    end
    chk("slot5_dwell", c, 2);
    chk("lowered_last_idx", slot_idx, 3'd0);
    chk("lowered_last_wrap", wrap, 1'b1);

    // Reset mid-sequence clears outputs and the slot table.
    stop = 1'b1;
    step();
    stop = 1'b0;
    write_slot(3'd0, 24'h0A0B0C, 16'd2);
    seq_last = 3'd0;
    pulse_start();
    repeat (30) step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst2_duties", {red_duty, green_duty, blue_duty}, 24'h000000);
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_slot_idx", slot_idx, 3'd0);
    chk("rst2_wr_ready", wr_if.wr_ready, 1'b1);
    pulse_start();
    wait_hold(cyc, jumps);
    chk("rst2_table_cleared", cyc, 2);
    chk("rst2_hold_color", {red_duty, green_duty, blue_duty}, 24'h000000);
    write_slot(3'd0, 24'h010000, 16'd0);
    pulse_start();
    wait_hold(cyc, jumps);
    chk_rng("post_rst_write_fade", cyc, 3, 12);
    chk("post_rst_write_color", {red_duty, green_duty, blue_duty}, 24'h010000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
